// File: rtl/store_buffer.sv
// Circular store buffer between a single-cycle core and data memory.
// Merges repeat stores, forwards pending data to loads, and drains the head via mem_req/mem_ack.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemWrite,
  input  logic [31:0]            DataAdr,
  input  logic [31:0]            WriteData,
  output logic                   Stall,
  output logic                   LdHit,
  output logic [31:0]            LdData,
  output logic                   mem_req,
  output logic [31:0]            mem_adr,
  output logic [31:0]            mem_wdata,
  input  logic                   mem_ack,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic [29:0]   adr_q  [DEPTH];
  logic [31:0]   data_q [DEPTH];

  logic [PW-1:0] idx;
  logic [PW-1:0] merge_idx;
  logic          merge_hit;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic          full;
  logic          merge;
  logic          enq;
  logic          pop;
  logic          unused_adr_lsb;

  assign unused_adr_lsb = ^DataAdr[1:0];

  // Walk pending entries oldest to youngest so the last match wins.
  always_comb begin
    idx       = '0;
    merge_idx = '0;
    merge_hit = 1'b0;
    fwd_hit   = 1'b0;
    fwd_data  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if ((CW'(k) < count_q) && (adr_q[idx] == DataAdr[31:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
        // The head may already be in flight to memory, so it never absorbs a merge.
        if (k != 0) begin
          merge_hit = 1'b1;
          merge_idx = idx;
        end
      end
    end
  end

  assign full      = (count_q == CW'(DEPTH));
  assign merge     = MemWrite & merge_hit;
  assign Stall     = MemWrite & full & ~merge_hit;
  assign enq       = MemWrite & ~merge_hit & ~full;
  assign pop       = mem_req & mem_ack;

  assign LdHit     = ~MemWrite & fwd_hit;
  assign LdData    = MemWrite ? 32'd0 : fwd_data;

  assign Count     = count_q;
  assign Empty     = (count_q == '0);
  assign mem_req   = ~Empty;
  assign mem_adr   = mem_req ? {adr_q[head_q], 2'b00} : 32'd0;
  assign mem_wdata = mem_req ? data_q[head_q] : 32'd0;

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail_q <= tail_q + PW'(1);
      if (pop) head_q <= head_q + PW'(1);
      case ({enq, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (enq) begin
      adr_q[tail_q]  <= DataAdr[31:2];
      data_q[tail_q] <= WriteData;
    end else if (merge) begin
      data_q[merge_idx] <= WriteData;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed test of store_buffer: enqueue, stall, merge, forwarding, drain and reset.
module tb_store_buffer;

  logic        clk;
  logic        reset;
  logic        mem_write;
  logic [31:0] data_adr;
  logic [31:0] write_data;
  logic        stall;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        mem_req;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [2:0]  count;
  logic        empty;

  int pass_cnt;
  int total_cnt;

  store_buffer #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (mem_write),
    .DataAdr   (data_adr),
    .WriteData (write_data),
    .Stall     (stall),
    .LdHit     (ld_hit),
    .LdData    (ld_data),
    .mem_req   (mem_req),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .Count     (count),
    .Empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic k);
    mem_write  = w;
    data_adr   = a;
    write_data = d;
    mem_ack    = k;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    reset = 1'b0;
    #1;
    total_cnt++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (empty !== 1'b1) $display("FAIL reset_empty got %0b want 1", empty); else pass_cnt++;
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %0b want 0", mem_req); else pass_cnt++;
    total_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall got %0b want 0", stall); else pass_cnt++;
    total_cnt++; if ({ld_hit, ld_data} !== 33'd0) $display("FAIL reset_ld got %0b/%0d want 0/0", ld_hit, ld_data); else pass_cnt++;
    total_cnt++; if ({mem_adr, mem_wdata} !== 64'd0) $display("FAIL reset_mem_bus got %0d/%0d want 0/0", mem_adr, mem_wdata); else pass_cnt++;
    #8;
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    drive(1'b1, 32'd100, 32'd4096, 1'b0);
    total_cnt++; if (ld_hit !== 1'b0) $display("FAIL single_ld_during_store got %0b want 0", ld_hit); else pass_cnt++;
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL single_req_before_capture got %0b want 0", mem_req); else pass_cnt++;
    step();
    drive(1'b0, 32'd102, 32'd0, 1'b0);
    total_cnt++; if (mem_req !== 1'b1) $display("FAIL single_mem_req got %0b want 1", mem_req); else pass_cnt++;
    total_cnt++; if (mem_adr !== 32'd100) $display("FAIL single_mem_adr got %0d want 100", mem_adr); else pass_cnt++;
    total_cnt++; if (mem_wdata !== 32'd4096) $display("FAIL single_mem_wdata got %0d want 4096", mem_wdata); else pass_cnt++;
    total_cnt++; if (count !== 3'd1) $display("FAIL single_count got %0d want 1", count); else pass_cnt++;
    total_cnt++; if ({ld_hit, ld_data} !== {1'b1, 32'd4096}) $display("FAIL single_fwd got %0b/%0d want 1/4096", ld_hit, ld_data); else pass_cnt++;
    step();
    total_cnt++; if (mem_adr !== 32'd100) $display("FAIL single_adr_stable got %0d want 100", mem_adr); else pass_cnt++;
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    step();
    drive(1'b0, 32'd100, 32'd0, 1'b0);
    total_cnt++; if ({count, empty} !== {3'd0, 1'b1}) $display("FAIL single_drained got %0d/%0b want 0/1", count, empty); else pass_cnt++;
    total_cnt++; if ({mem_req, ld_hit} !== 2'b00) $display("FAIL single_idle got req %0b hit %0b want 0/0", mem_req, ld_hit); else pass_cnt++;
  endtask

  task automatic test_full_stall();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'd96 + 32'(4 * i), 32'd1096 + 32'(4 * i), 1'b0);
      step();
    end
    drive(1'b1, 32'd112, 32'd1112, 1'b0);
    total_cnt++; if (stall !== 1'b1) $display("FAIL full_stall got %0b want 1", stall); else pass_cnt++;
    total_cnt++; if (count !== 3'd4) $display("FAIL full_count got %0d want 4", count); else pass_cnt++;
    drive(1'b1, 32'd112, 32'd1112, 1'b1);
    total_cnt++; if (stall !== 1'b1) $display("FAIL full_stall_with_ack got %0b want 1", stall); else pass_cnt++;
    step();
    drive(1'b1, 32'd112, 32'd1112, 1'b0);
    total_cnt++; if (stall !== 1'b0) $display("FAIL full_stall_released got %0b want 0", stall); else pass_cnt++;
    total_cnt++; if ({count, mem_adr} !== {3'd3, 32'd100}) $display("FAIL full_after_pop got %0d/%0d want 3/100", count, mem_adr); else pass_cnt++;
    step();
    drive(1'b0, 32'd112, 32'd0, 1'b0);
    total_cnt++; if (count !== 3'd4) $display("FAIL full_accepted_count got %0d want 4", count); else pass_cnt++;
    total_cnt++; if ({ld_hit, ld_data} !== {1'b1, 32'd1112}) $display("FAIL full_fwd112 got %0b/%0d want 1/1112", ld_hit, ld_data); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      total_cnt++;
      if ({mem_adr, mem_wdata} !== {32'd100 + 32'(4 * i), 32'd1100 + 32'(4 * i)})
        $display("FAIL full_drain%0d got %0d/%0d want %0d/%0d", i, mem_adr, mem_wdata, 100 + 4 * i, 1100 + 4 * i);
      else pass_cnt++;
      step();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    total_cnt++; if ({count, empty} !== {3'd0, 1'b1}) $display("FAIL full_drained got %0d/%0b want 0/1", count, empty); else pass_cnt++;
  endtask

  task automatic test_merge();
    drive(1'b1, 32'd96, 32'd1, 1'b0);
    step();
    drive(1'b1, 32'd100, 32'd7, 1'b0);
    step();
    drive(1'b1, 32'd100, 32'd9, 1'b0);
    total_cnt++; if (stall !== 1'b0) $display("FAIL merge_stall got %0b want 0", stall); else pass_cnt++;
    step();
    drive(1'b0, 32'd100, 32'd0, 1'b0);
    total_cnt++; if (count !== 3'd2) $display("FAIL merge_count got %0d want 2", count); else pass_cnt++;
    total_cnt++; if ({ld_hit, ld_data} !== {1'b1, 32'd9}) $display("FAIL merge_fwd100 got %0b/%0d want 1/9", ld_hit, ld_data); else pass_cnt++;
    drive(1'b1, 32'd96, 32'd5, 1'b0);
    step();
    drive(1'b0, 32'd96, 32'd0, 1'b0);
    total_cnt++; if (count !== 3'd3) $display("FAIL merge_head_enq_count got %0d want 3", count); else pass_cnt++;
    total_cnt++; if ({ld_hit, ld_data} !== {1'b1, 32'd5}) $display("FAIL merge_fwd96_youngest got %0b/%0d want 1/5", ld_hit, ld_data); else pass_cnt++;
    total_cnt++; if (mem_wdata !== 32'd1) $display("FAIL merge_head_untouched got %0d want 1", mem_wdata); else pass_cnt++;
    drive(1'b1, 32'd96, 32'd6, 1'b0);
    step();
    drive(1'b0, 32'd96, 32'd0, 1'b0);
    total_cnt++; if ({count, ld_data} !== {3'd3, 32'd6}) $display("FAIL merge_dup96 got %0d/%0d want 3/6", count, ld_data); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      total_cnt++;
      if (mem_wdata !== ((i == 0) ? 32'd1 : (i == 1) ? 32'd9 : 32'd6))
        $display("FAIL merge_drain%0d got %0d want %0d", i, mem_wdata, (i == 0) ? 1 : (i == 1) ? 9 : 6);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_full_merge();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 32'(i + 1), 1'b0);
      step();
    end
    drive(1'b1, 32'h208, 32'hAB, 1'b0);
    total_cnt++; if (stall !== 1'b0) $display("FAIL fmerge_stall got %0b want 0", stall); else pass_cnt++;
    step();
    drive(1'b0, 32'h208, 32'd0, 1'b0);
    total_cnt++; if ({count, ld_data} !== {3'd4, 32'hAB}) $display("FAIL fmerge_result got %0d/%0h want 4/ab", count, ld_data); else pass_cnt++;
    drive(1'b1, 32'h200, 32'hEE, 1'b0);
    total_cnt++; if (stall !== 1'b1) $display("FAIL fmerge_head_stall got %0b want 1", stall); else pass_cnt++;
    drive(1'b1, 32'h20C, 32'hCD, 1'b1);
    total_cnt++; if (stall !== 1'b0) $display("FAIL fmerge_pop_stall got %0b want 0", stall); else pass_cnt++;
    step();
    drive(1'b0, 32'h20C, 32'd0, 1'b0);
    total_cnt++; if ({count, mem_adr} !== {3'd3, 32'h204}) $display("FAIL fmerge_pop got %0d/%0h want 3/204", count, mem_adr); else pass_cnt++;
    total_cnt++; if ({ld_hit, ld_data} !== {1'b1, 32'hCD}) $display("FAIL fmerge_pop_merge got %0b/%0h want 1/cd", ld_hit, ld_data); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      step();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    total_cnt++; if (empty !== 1'b1) $display("FAIL fmerge_drained got %0b want 1", empty); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h300, 32'd1, 1'b0);
    step();
    drive(1'b1, 32'h304, 32'd2, 1'b0);
    step();
    drive(1'b1, 32'h308, 32'd3, 1'b1);
    total_cnt++; if (count !== 3'd2) $display("FAIL b2b_pre_count got %0d want 2", count); else pass_cnt++;
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    total_cnt++; if ({count, mem_adr} !== {3'd2, 32'h304}) $display("FAIL b2b_after got %0d/%0h want 2/304", count, mem_adr); else pass_cnt++;
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    step();
    total_cnt++; if ({mem_adr, mem_wdata} !== {32'h308, 32'd3}) $display("FAIL b2b_tail got %0h/%0d want 308/3", mem_adr, mem_wdata); else pass_cnt++;
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    total_cnt++; if (empty !== 1'b1) $display("FAIL b2b_drained got %0b want 1", empty); else pass_cnt++;
  endtask

  task automatic test_ack_idle();
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    step();
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    total_cnt++; if ({count, empty, mem_req} !== {3'd0, 1'b1, 1'b0}) $display("FAIL idle_ack got %0d/%0b/%0b want 0/1/0", count, empty, mem_req); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h400 + 32'(4 * i), 32'(i + 10), 1'b0);
      step();
    end
    drive(1'b0, 32'h400, 32'd0, 1'b0);
    total_cnt++; if ({count, mem_req} !== {3'd3, 1'b1}) $display("FAIL rmid_pre got %0d/%0b want 3/1", count, mem_req); else pass_cnt++;
    #2;
    reset = 1'b0;
    #1;
    total_cnt++; if ({count, mem_req, empty} !== {3'd0, 1'b0, 1'b1}) $display("FAIL rmid_async got %0d/%0b/%0b want 0/0/1", count, mem_req, empty); else pass_cnt++;
    total_cnt++; if ({ld_hit, mem_adr, mem_wdata} !== 65'd0) $display("FAIL rmid_outputs got %0b/%0h/%0d want 0/0/0", ld_hit, mem_adr, mem_wdata); else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    total_cnt++; if ({count, mem_req} !== {3'd0, 1'b0}) $display("FAIL rmid_no_reissue got %0d/%0b want 0/0", count, mem_req); else pass_cnt++;
    drive(1'b1, 32'h500, 32'd77, 1'b0);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    total_cnt++; if ({count, mem_adr, mem_wdata} !== {3'd1, 32'h500, 32'd77}) $display("FAIL rmid_new got %0d/%0h/%0d want 1/500/77", count, mem_adr, mem_wdata); else pass_cnt++;
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_single();
    test_full_stall();
    test_merge();
    test_full_merge();
    test_back_to_back();
    test_ack_idle();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of pending-store entries (power of two, >=2).
REQ-002 clk  input  1  rising-edge clock shared with the single-cycle core.
REQ-003 reset  input  1  asynchronous reset, active-low: asserted when 0.
REQ-004 MemWrite  input  1  core store strobe this cycle.
REQ-005 DataAdr  input  32  core byte address, for stores and loads; bits [1:0] ignored.
REQ-006 WriteData  input  32  core store data.
REQ-007 Stall  output  1  core SHALL hold its PC and state this cycle.
REQ-008 LdHit  output  1  DataAdr word matches a pending entry.
REQ-009 LdData  output  32  forwarded data for LdHit.
REQ-010 mem_req  output  1  write request to data memory.
REQ-011 mem_adr  output  32  request word address, bits [1:0] = 0.
REQ-012 mem_wdata  output  32  request data.
REQ-013 mem_ack  input  1  memory accepted the head request this cycle.
REQ-014 Count  output  $clog2(DEPTH)+1  pending entries.
REQ-015 Empty  output  1  Count == 0.

Function
REQ-016 The buffer SHALL be a circular FIFO: entries {adr[31:2], data}, head/tail pointers wrap modulo DEPTH.
REQ-017 Merge: MemWrite with DataAdr[31:2] equal to a pending non-head entry SHALL overwrite the youngest such entry's data; Count unchanged.
REQ-018 A match on the head entry while mem_req=1 SHALL NOT merge; store enqueues as a new entry.
REQ-019 Enqueue: MemWrite, no merge, Count<DEPTH -> write at tail on next edge, Count+1.
REQ-020 Stall SHALL equal MemWrite & (Count==DEPTH) & ~merge, combinational; stalled store is not captured.
REQ-021 Stall SHALL NOT be relieved by a same-cycle mem_ack; store is accepted on the following cycle.
REQ-022 mem_req SHALL equal ~Empty; mem_adr/mem_wdata SHALL present the head and remain stable until mem_ack.
REQ-023 mem_req & mem_ack SHALL pop the head on that edge.
REQ-024 Simultaneous pop and enqueue SHALL leave Count unchanged; pointers both advance.
REQ-025 Simultaneous pop of head and merge into another entry SHALL both take effect.
REQ-026 mem_ack while mem_req=0 SHALL be ignored.
REQ-027 When MemWrite=0: LdHit SHALL be 1 if any pending entry (head included) matches DataAdr[31:2]; LdData SHALL be the youngest match, else 0.
REQ-028 When MemWrite=1: LdHit=0, LdData=0.
REQ-029 Latency: a store enqueued into an empty buffer SHALL raise mem_req the cycle after capture.

Reset
REQ-030 reset=0 SHALL immediately clear pointers and Count; Empty=1, mem_req=0, Stall=0, LdHit=0, LdData=0, mem_adr=0, mem_wdata=0.
REQ-031 Reset mid-request SHALL discard all pending entries; no write is reissued after release.
REQ-032 Entry storage need not be cleared; only pointers and Count are reset.

Verification
REQ-033 Store adr 100 data 4096, mem_ack held 0 -> next cycle mem_req=1, mem_adr=100, mem_wdata=4096, Count=1; ack -> Count=0, Empty=1.
REQ-034 Stores to 96,100,104,108, ack=0, then store to 112 -> Stall=1, Count=4; ack one cycle -> next cycle store 112 accepted, Count=4.
REQ-035 Pending 96(head, requesting), 100=7; store 100=9 -> Count unchanged; load 100 -> LdHit=1, LdData=9; store 96=5 -> Count+1.
REQ-036 Full buffer, store to non-head pending address -> Stall=0, merged, Count=DEPTH.
REQ-037 Enqueue and ack same cycle with Count=2 -> Count stays 2; head advances to the second entry's address.
REQ-038 reset=0 between edges with Count=3, mem_req=1 -> mem_req=0, Count=0 immediately; no request after release until a new store.
